// File: rtl/exc_writeback.sv
// Two-stage exception writeback pipeline (X/M, M/W) with status-register override and bypass export.
// Optional feature macro: EXC_COUNT_EN enables the saturating committed-exception counter.
module exc_writeback #(
  parameter int unsigned STATUS_REG = 30,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             x_valid,
  input  logic             x_we,
  input  logic [4:0]       x_rd,
  input  logic [31:0]      x_result,
  input  logic             x_ovf,
  input  logic             x_is_md,
  input  logic             md_ready,
  input  logic             md_exc,
  input  logic [31:0]      x_rstatus,
  output logic             m_we,
  output logic [4:0]       m_rd,
  output logic [31:0]      m_data,
  output logic             w_we,
  output logic [4:0]       w_rd,
  output logic [31:0]      w_data,
  output logic             exc_pending,
  output logic [CNT_W-1:0] exc_count
);

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
  } stage_t;

  localparam stage_t BUBBLE = '0;
  localparam logic [4:0] STATUS_RD = 5'(STATUS_REG);

  stage_t xm_d, xm_q, mw_q;
  logic   ovf_sel, rstat_nz, exc, cap;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    ovf_sel  = x_is_md ? (md_ready & md_exc) : x_ovf;
    rstat_nz = (x_rstatus != '0);
    exc      = x_valid & ovf_sel & rstat_nz;
    cap      = x_valid & (~x_is_md | md_ready);
    xm_d     = BUBBLE;
    if (cap) begin
      // An unknown status makes exc unknown; the if falls to the normal write, suppressing the override.
      if (exc) begin
        xm_d.we   = 1'b1;
        xm_d.rd   = STATUS_RD;
        xm_d.data = x_rstatus;
        xm_d.exc  = 1'b1;
      end else begin
        xm_d.we   = x_we & (x_rd != 5'd0);
        xm_d.rd   = x_rd;
        xm_d.data = x_result;
        xm_d.exc  = 1'b0;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so both latches sample pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      xm_q <= BUBBLE;
      mw_q <= BUBBLE;
    end else begin
      // Flush beats stall for X/M; M/W only ever obeys stall.
      if (flush) begin
        xm_q <= BUBBLE;
      end else if (!stall) begin
        xm_q <= xm_d;
      end
      if (!stall) begin
        mw_q <= xm_q;
      end
    end
  end

  assign m_we        = xm_q.we;
  assign m_rd        = xm_q.rd;
  assign m_data      = xm_q.data;
  assign w_we        = mw_q.we;
  assign w_rd        = mw_q.rd;
  assign w_data      = mw_q.data;
  assign exc_pending = xm_q.exc | mw_q.exc;

`ifdef EXC_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts once per committed instruction: a stalled M/W holds its flag but does not re-count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (mw_q.exc && !stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign exc_count = cnt_q;
`else
  assign exc_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_exc_writeback.sv
// Scoreboard bench for exc_writeback: stimulus pushes expected register-file writes, a monitor pops and compares.
module tb_exc_writeback;

`ifdef EXC_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        x_valid = 1'b0, x_we = 1'b0;
  logic [4:0]  x_rd = '0;
  logic [31:0] x_result = '0;
  logic        x_ovf = 1'b0, x_is_md = 1'b0, md_ready = 1'b0, md_exc = 1'b0;
  logic [31:0] x_rstatus = '0;
  logic        m_we, w_we, exc_pending;
  logic [4:0]  m_rd, w_rd;
  logic [31:0] m_data, w_data;
  logic [7:0]  exc_count;

  exc_writeback dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .flush(flush),
    .x_valid(x_valid), .x_we(x_we), .x_rd(x_rd), .x_result(x_result),
    .x_ovf(x_ovf), .x_is_md(x_is_md), .md_ready(md_ready), .md_exc(md_exc),
    .x_rstatus(x_rstatus),
    .m_we(m_we), .m_rd(m_rd), .m_data(m_data),
    .w_we(w_we), .w_rd(w_rd), .w_data(w_data),
    .exc_pending(exc_pending), .exc_count(exc_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  cnt_model = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
    return CNT_EN ? 32'(cnt_model) : 32'd0;
  endfunction

  task automatic bump(input int n);
    cnt_model = cnt_model + n;
    if (cnt_model > 255) cnt_model = 255;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic issue(input logic we, input logic [4:0] rd, input logic [31:0] res,
                       input logic ovf, input logic is_md, input logic rdy, input logic mexc,
                       input logic [31:0] rstat,
                       input logic exp_we, input logic [4:0] exp_rd, input logic [31:0] exp_data);
    x_valid = 1'b1; x_we = we; x_rd = rd; x_result = res; x_ovf = ovf;
    x_is_md = is_md; md_ready = rdy; md_exc = mexc; x_rstatus = rstat;
    if (exp_we) exp_q.push_back('{exp_rd, exp_data});
    step();
    x_valid = 1'b0; x_we = 1'b0; x_rd = '0; x_result = '0; x_ovf = 1'b0;
    x_is_md = 1'b0; md_ready = 1'b0; md_exc = 1'b0; x_rstatus = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_we"}, m_we, 0);
    check({tag, "_m_rd"}, m_rd, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_w_we"}, w_we, 0);
    check({tag, "_w_rd"}, w_rd, 0);
    check({tag, "_w_data"}, w_data, 0);
    check({tag, "_pending"}, exc_pending, 0);
    check({tag, "_count"}, exc_count, 0);
  endtask

  // Monitor: a write is presented after every non-stalled edge out of reset where w_we is high.
  initial begin : monitor
    logic upd;
    wr_t  e;
    forever begin
      @(posedge clock);
      upd = !stall && reset_n;
      @(negedge clock);
      if (reset_n && upd && w_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", w_we, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("w_rd", w_rd, e.rd);
          check("w_data", w_data, e.data);
        end
      end
    end
  end

  initial begin : stimulus
    idle(3);
    check_all_zero("reset");
    #2 reset_n = 1'b1;
    idle(2);

    // add overflow, status 1, rd 5 -> r30 = 1
    issue(1, 5'd5, 32'hdead, 1, 0, 0, 0, 32'd1, 1, 5'd30, 32'd1);
    check("add_m_we", m_we, 1);
    check("add_m_rd", m_rd, 30);
    check("add_m_data", m_data, 1);
    check("add_pending", exc_pending, 1);
    idle(2);
    bump(1);
    check("add_count", exc_count, exp_cnt());
    check("add_pending_clear", exc_pending, 0);

    // addi without overflow writes its own result and is not counted
    issue(1, 5'd7, 32'h1234, 0, 0, 0, 0, 32'd2, 1, 5'd7, 32'h1234);
    check("addi_m_rd", m_rd, 7);
    idle(2);
    check("addi_count", exc_count, exp_cnt());

    // mult/div busy: stalled 33 cycles, then one unstalled not-ready cycle (bubble)
    x_valid = 1'b1; x_is_md = 1'b1; x_we = 1'b1; x_rd = 5'd20; stall = 1'b1;
    idle(33);
    check("md_stall_m_we", m_we, 0);
    check("md_stall_pending", exc_pending, 0);
    stall = 1'b0;
    step();
    check("md_notready_m_we", m_we, 0);
    issue(1, 5'd20, 32'h0, 0, 1, 1, 1, 32'd5, 1, 5'd30, 32'd5);
    check("md_pending", exc_pending, 1);
    idle(2);
    bump(1);
    check("md_count", exc_count, exp_cnt());

    // exception held in M/W through a 4-cycle stall: frozen, counted once
    issue(1, 5'd9, 32'h99, 1, 0, 0, 0, 32'd3, 1, 5'd30, 32'd3);
    step();
    stall = 1'b1;
    idle(4);
    check("hold_count", exc_count, exp_cnt());
    check("hold_w_we", w_we, 1);
    check("hold_w_rd", w_rd, 30);
    check("hold_w_data", w_data, 3);
    check("hold_pending", exc_pending, 1);
    stall = 1'b0;
    step();
    bump(1);
    check("hold_count_once", exc_count, exp_cnt());
    step();
    check("hold_count_no_repeat", exc_count, exp_cnt());

    // overflow in X/M flushed while stalled: never written, never counted
    issue(1, 5'd4, 32'hbeef, 1, 0, 0, 0, 32'd1, 0, 5'd0, 32'd0);
    check("flush_pending_before", exc_pending, 1);
    stall = 1'b1; flush = 1'b1;
    step();
    check("flush_pending_after", exc_pending, 0);
    check("flush_m_we", m_we, 0);
    stall = 1'b0; flush = 1'b0;
    idle(3);
    check("flush_count", exc_count, exp_cnt());

    // rd 0 without overflow is dropped; with overflow it is redirected to r30
    issue(1, 5'd0, 32'h55, 0, 0, 0, 0, 32'd1, 0, 5'd0, 32'd0);
    check("r0_m_we", m_we, 0);
    issue(1, 5'd0, 32'h55, 1, 0, 0, 0, 32'd1, 1, 5'd30, 32'd1);
    idle(2);
    bump(1);
    check("r0_ovf_count", exc_count, exp_cnt());

    // overflow with zero status: normal write, no count
    issue(1, 5'd6, 32'h77, 1, 0, 0, 0, 32'd0, 1, 5'd6, 32'h77);
    check("zstat_pending", exc_pending, 0);
    idle(2);
    check("zstat_count", exc_count, exp_cnt());

    // back-to-back exceptions count on consecutive cycles
    issue(1, 5'd1, 32'h1, 1, 0, 0, 0, 32'd1, 1, 5'd30, 32'd1);
    issue(1, 5'd2, 32'h2, 1, 0, 0, 0, 32'd2, 1, 5'd30, 32'd2);
    issue(1, 5'd3, 32'h3, 1, 0, 0, 0, 32'd3, 1, 5'd30, 32'd3);
    bump(1);
    check("b2b_count_1", exc_count, exp_cnt());
    step();
    bump(1);
    check("b2b_count_2", exc_count, exp_cnt());
    step();
    bump(1);
    check("b2b_count_3", exc_count, exp_cnt());
    idle(2);

    // 256 exceptions saturate the counter
    for (int i = 0; i < 256; i++) begin
      issue(1, 5'(i), 32'(i), 1, 0, 0, 0, 32'(i + 1), 1, 5'd30, 32'(i + 1));
    end
    idle(2);
    bump(256);
    check("sat_count", exc_count, CNT_EN ? 32'd255 : 32'd0);

    // asynchronous reset mid-stream clears everything immediately
    issue(1, 5'd1, 32'h1, 1, 0, 0, 0, 32'd4, 1, 5'd30, 32'd4);
    issue(1, 5'd2, 32'h2, 1, 0, 0, 0, 32'd4, 1, 5'd30, 32'd4);
    issue(1, 5'd3, 32'h3, 1, 0, 0, 0, 32'd4, 1, 5'd30, 32'd4);
    #1 reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    cnt_model = 0;
    idle(2);
    reset_n = 1'b1;
    step();

    issue(1, 5'd8, 32'h8, 1, 0, 0, 0, 32'd2, 1, 5'd30, 32'd2);
    idle(2);
    bump(1);
    check("post_reset_count", exc_count, exp_cnt());
    idle(2);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
